// File: rtl/game2048_pkg.sv
// Shared constants, FSM state type and tile-code colour mapping for the
// 2048 board bus readers and writers.
package game2048_pkg;

  localparam int NUM_BOXES = 16;
  localparam int BOX_W     = 4;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int COLOUR_W  = 3;

  localparam logic [7:0] X0    = 8'd22;
  localparam logic [7:0] Y0    = 8'd2;
  localparam logic [7:0] TILE  = 8'd24;
  localparam logic [7:0] GAP   = 8'd4;
  localparam logic [7:0] PITCH = TILE + GAP;
  localparam logic [7:0] BOARD_SPAN = (8'd4 * TILE) + (8'd5 * GAP);

  localparam logic [COLOUR_W-1:0] EMPTY_COLOUR = 3'b001;
  localparam logic [COLOUR_W-1:0] GRID_COLOUR  = 3'b000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRID       = 3'd1,
    TILE_SETUP = 3'd2,
    TILE_DRAW  = 3'd3,
    NEXT_TILE  = 3'd4,
    FINISH     = 3'd5
  } state_t;

  // Codes whose low three bits are zero (8 and up) would otherwise alias black.
  function automatic logic [COLOUR_W-1:0] tile_colour(input logic [BOX_W-1:0] k);
    logic [COLOUR_W-1:0] c;
    if (k == 4'd0) begin
      c = EMPTY_COLOUR;
    end else if (k[2:0] == 3'd0) begin
      c = 3'b111;
    end else begin
      c = k[2:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/board_renderer_rect_scanner.sv
// Raster scanner: after a start pulse, walks a width x height rectangle
// row-major from its origin, one coordinate per cycle, flagging the last one.
module rect_scanner (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] org_x,
  input  logic [7:0] org_y,
  input  logic [7:0] width,
  input  logic [7:0] height,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       plot,
  output logic       last
);

  logic       active_r;
  logic [7:0] px_r;
  logic [7:0] py_r;
  logic [7:0] y_full_s;
  logic       row_end_s;

  assign row_end_s = (px_r == (width - 8'd1));
  assign y_full_s  = org_y + py_r;
  assign x         = org_x + px_r;
  assign y         = y_full_s[6:0];
  assign plot      = active_r;
  assign last      = active_r && row_end_s && (py_r == (height - 8'd1));

  // Position counters; px runs fastest, scan stops itself after the last pixel.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      active_r <= 1'b0;
      px_r     <= 8'd0;
      py_r     <= 8'd0;
    end else if (start) begin
      active_r <= 1'b1;
      px_r     <= 8'd0;
      py_r     <= 8'd0;
    end else if (active_r) begin
      if (last) begin
        active_r <= 1'b0;
        px_r     <= 8'd0;
        py_r     <= 8'd0;
      end else if (row_end_s) begin
        px_r <= 8'd0;
        py_r <= py_r + 8'd1;
      end else begin
        px_r <= px_r + 8'd1;
      end
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Snapshots the 64-bit board bus on draw_req and plots its 4x4 tiles to the
// VGA adapter one pixel per cycle. RENDER_GRID_EN adds a background fill pass.
module board_renderer
  import game2048_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                draw_req,
  input  logic [63:0]         board,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  state_t state_r, state_s;

  logic [63:0]         snap_r;
  logic [3:0]          tile_r;
  logic [COLOUR_W-1:0] tile_col_r;
  logic [5:0]          code_top_s;
  logic [BOX_W-1:0]    code_s;
  logic                accept_s, start_s, plot_s;
  logic [COLOUR_W-1:0] colour_s;
  logic [7:0]          org_x_s, org_y_s, span_w_s, span_h_s;
  logic [7:0]          scan_x_s;
  logic [6:0]          scan_y_s;
  logic                scan_plot_s, scan_last_s;

  assign accept_s   = (state_r == IDLE) && draw_req;
  assign code_top_s = 6'd63 - {tile_r, 2'b00};
  assign code_s     = snap_r[code_top_s -: BOX_W];

`ifdef RENDER_GRID_EN
  logic grid_tail_r;

  // Holds GRID for one blank cycle after the background scan completes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grid_tail_r <= 1'b0;
    end else if ((state_r == GRID) && scan_last_s) begin
      grid_tail_r <= 1'b1;
    end else if (state_r != GRID) begin
      grid_tail_r <= 1'b0;
    end else begin
      grid_tail_r <= grid_tail_r;
    end
  end
`endif

  // Scanner geometry: whole board for the background pass, else the current tile.
  always_comb begin
    org_x_s  = X0 + GAP + ({6'd0, tile_r[1:0]} * PITCH);
    org_y_s  = Y0 + GAP + ({6'd0, tile_r[3:2]} * PITCH);
    span_w_s = TILE;
    span_h_s = TILE;
    start_s  = (state_r == TILE_SETUP);
    plot_s   = scan_plot_s && (state_r == TILE_DRAW);
    colour_s = tile_col_r;
`ifdef RENDER_GRID_EN
    if ((state_r == IDLE) || (state_r == GRID)) begin
      org_x_s  = X0;
      org_y_s  = Y0;
      span_w_s = BOARD_SPAN;
      span_h_s = BOARD_SPAN;
      colour_s = GRID_COLOUR;
    end else begin
      colour_s = tile_col_r;
    end
    start_s = start_s || accept_s;
    plot_s  = scan_plot_s && ((state_r == TILE_DRAW) || (state_r == GRID));
`endif
  end

  rect_scanner u_scanner (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_s),
    .org_x   (org_x_s),
    .org_y   (org_y_s),
    .width   (span_w_s),
    .height  (span_h_s),
    .x       (scan_x_s),
    .y       (scan_y_s),
    .plot    (scan_plot_s),
    .last    (scan_last_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef RENDER_GRID_EN
          state_s = GRID;
`else
          state_s = TILE_SETUP;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef RENDER_GRID_EN
      GRID: begin
        if (grid_tail_r) begin
          state_s = TILE_SETUP;
        end else begin
          state_s = GRID;
        end
      end
`endif
      TILE_SETUP: state_s = TILE_DRAW;
      TILE_DRAW: begin
        if (scan_last_s) begin
          state_s = NEXT_TILE;
        end else begin
          state_s = TILE_DRAW;
        end
      end
      NEXT_TILE: begin
        if (tile_r == 4'(NUM_BOXES - 1)) begin
          state_s = FINISH;
        end else begin
          state_s = TILE_SETUP;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Board snapshot, tile index and per-tile colour.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      snap_r     <= 64'd0;
      tile_r     <= 4'd0;
      tile_col_r <= 3'd0;
    end else begin
      if (accept_s) begin
        snap_r <= board;
        tile_r <= 4'd0;
      end else if (state_r == NEXT_TILE) begin
        tile_r <= tile_r + 4'd1;
      end else begin
        tile_r <= tile_r;
      end
      if (state_r == TILE_SETUP) begin
        tile_col_r <= tile_colour(code_s);
      end else begin
        tile_col_r <= tile_col_r;
      end
    end
  end

  // Registered pixel and handshake outputs; done/busy track entry into FINISH.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot   <= plot_s;
      x      <= plot_s ? scan_x_s : 8'd0;
      y      <= plot_s ? scan_y_s : 7'd0;
      colour <= plot_s ? colour_s : 3'd0;
      done   <= (state_s == FINISH);
      if (accept_s) begin
        busy <= 1'b1;
      end else if (state_s == FINISH) begin
        busy <= 1'b0;
      end else begin
        busy <= busy;
      end
    end
  end

endmodule
